cdb_arbiter: RTL
================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_REQ, default 4, the number of completion requesters (FU0, FU1, FU2, MEM).
REQ-002 The module SHALL have parameter NUM_PORTS, default 2, the number of result-broadcast (CDB) ports.
REQ-003 The module SHALL have parameters DATA_W, default 32, result width; TAG_W, default 6, physical register tag width; ROB_W, default 6, ROB index width.
REQ-004 The module SHALL have the following ports, one per line, as name, direction, width and meaning:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous pipeline flush.
- req_valid  input  NUM_REQ  per-requester result valid.
- req_ready  output  NUM_REQ  per-requester accept.
- req_tag  input  NUM_REQ*TAG_W  flat physical destination tags, requester i at slice i.
- req_rob  input  NUM_REQ*ROB_W  flat ROB indices.
- req_data  input  NUM_REQ*DATA_W  flat results.
- cdb_valid  output  NUM_PORTS  broadcast valid per port.
- cdb_tag  output  NUM_PORTS*TAG_W  broadcast tags.
- cdb_rob  output  NUM_PORTS*ROB_W  broadcast ROB indices.
- cdb_data  output  NUM_PORTS*DATA_W  broadcast results.
- cdb_src  output  NUM_PORTS*2  index of the requester driving each port.

Function
REQ-005 Each requester SHALL own a one-entry hold register (valid, tag, rob, data).
REQ-006 req_ready[i] SHALL equal !flush && (!hold_valid[i] || grant[i]), combinationally.
REQ-007 A handshake (req_valid[i] && req_ready[i]) at a rising edge SHALL load hold register i at that edge.
REQ-008 Grant candidates each cycle SHALL be the hold registers with valid set; incoming requests SHALL NOT bypass the hold.
REQ-009 Up to NUM_PORTS candidates SHALL be granted per cycle.
REQ-010 Grants SHALL be made in round-robin order starting at rr_ptr and wrapping modulo NUM_REQ.
REQ-011 The first granted candidate SHALL go to port 0 and the second to port 1.
REQ-012 cdb_* outputs SHALL be registered: an entry granted in cycle k SHALL appear on the CDB in cycle k+1, with cdb_valid high for exactly one cycle.
REQ-013 Minimum latency SHALL therefore be 2 cycles from handshake to broadcast.
REQ-014 A granted hold SHALL clear at the grant edge unless it is simultaneously refilled by a new handshake (back-to-back throughput of 1 per requester per cycle).
REQ-015 rr_ptr SHALL update to (last granted index + 1) mod NUM_REQ and SHALL remain unchanged when nothing is granted.
REQ-016 Ports with no grant SHALL drive cdb_valid=0; their tag, rob, data and src fields SHALL be don't-care but held stable.
REQ-017 When flush is asserted, the next edge SHALL clear all hold valids and all cdb_valid, SHALL perform no grants, and SHALL leave rr_ptr unchanged.
REQ-018 Flush SHALL take priority over a simultaneous req_valid: no handshake occurs.
REQ-019 With all NUM_REQ holds full, exactly NUM_PORTS SHALL drain per cycle; no entry SHALL wait more than ceil(NUM_REQ/NUM_PORTS) grant cycles (starvation-free).
REQ-020 Tags SHALL pass through unmodified; duplicate tags SHALL NOT be checked.

Reset
REQ-021 Asserting reset SHALL immediately clear all hold valids, all cdb_valid, rr_ptr=0, cdb_tag/rob/data/src=0, regardless of clock.
REQ-022 Reset asserted mid-operation SHALL discard all held and in-flight results.
REQ-023 After reset deasserts, req_ready SHALL read all ones.

Structure
REQ-024 A shared package SHALL hold DATA_W, TAG_W and ROB_W defaults, plus the requester index constants FU0=0, FU1=1, FU2=2, MEM=3.
REQ-025 One sub-module, rr_pick2, SHALL be instantiated: a combinational two-winner round-robin picker (valid vector and pointer in; two one-hot grants and found flags out).

Verification
REQ-026 Single request: after reset, FU1 presents tag 0x05, data 0x1234 -> cdb_valid[0]=1, tag 0x05, data 0x1234, src=1 two cycles after handshake; port 1 stays idle.
REQ-027 All four requesters present in the same cycle with rr_ptr=0 -> next cycle ports 0/1 carry FU0/FU1, following cycle FU2/MEM, rr_ptr ends at 0.
REQ-028 FU0 streams continuously while MEM is held valid -> FU0 and MEM each broadcast at least once every 2 cycles; FU0 req_ready never drops.
REQ-029 Three holds valid and flush asserted -> next cycle cdb_valid=0 and req_ready=1111; no stale tag is ever broadcast.
REQ-030 Reset asserted between clock edges while holds are full -> cdb_valid=0 before the next edge; rr_ptr=0.
REQ-031 Wrap case: rr_ptr=3, requesters 3 and 0 valid -> port 0 src=3, port 1 src=0, rr_ptr becomes 1.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared widths, requester indices and helpers for the CDB arbiter
package cdb_arbiter_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_TAG_W  = 6;
    localparam int DEF_ROB_W  = 6;

    // Width of the per-port source index on the broadcast bus
    localparam int SRC_W = 2;

    // The picker produces at most two winners per cycle
    localparam int MAX_PICK = 2;

    // Requester slots on the completion side
    localparam logic [SRC_W-1:0] FU0 = 2'd0;
    localparam logic [SRC_W-1:0] FU1 = 2'd1;
    localparam logic [SRC_W-1:0] FU2 = 2'd2;
    localparam logic [SRC_W-1:0] MEM = 2'd3;

    // Round-robin successor of an index in a ring of n slots
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick2.sv
// rtl/cdb_arbiter_rr_pick2.sv - combinational two-winner round-robin picker
module rr_pick2 #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     i_valid,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt0,
    output logic [N-1:0]     o_gnt1,
    output logic             o_found0,
    output logic             o_found1
);

    logic [PTR_W-1:0] w_idx;

    // Walk the ring from the pointer; first valid slot wins lane 0, second wins lane 1
    always_comb begin
        o_gnt0   = '0;
        o_gnt1   = '0;
        o_found0 = 1'b0;
        o_found1 = 1'b0;
        w_idx    = '0;
        for (int off = 0; off < N; off++) begin
            w_idx = PTR_W'((int'(i_ptr) + off) % N);
            if (i_valid[w_idx]) begin
                if (!o_found0) begin
                    o_gnt0[w_idx] = 1'b1;
                    o_found0      = 1'b1;
                end else if (!o_found1) begin
                    o_gnt1[w_idx] = 1'b1;
                    o_found1      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - arbitrates completion results from held requesters onto registered CDB ports
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int NUM_PORTS = 2,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int TAG_W     = DEF_TAG_W,
    parameter int ROB_W     = DEF_ROB_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
    input  logic [NUM_REQ*ROB_W-1:0]    req_rob,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_PORTS-1:0]        cdb_valid,
    output logic [NUM_PORTS*TAG_W-1:0]  cdb_tag,
    output logic [NUM_PORTS*ROB_W-1:0]  cdb_rob,
    output logic [NUM_PORTS*DATA_W-1:0] cdb_data,
    output logic [NUM_PORTS*SRC_W-1:0]  cdb_src
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // Ports beyond the picker's two lanes never carry a result
    localparam int LIVE  = (NUM_PORTS < MAX_PICK) ? NUM_PORTS : MAX_PICK;

    // One-entry hold per requester
    logic [NUM_REQ-1:0] r_hold_valid;
    logic [TAG_W-1:0]   r_hold_tag  [NUM_REQ];
    logic [ROB_W-1:0]   r_hold_rob  [NUM_REQ];
    logic [DATA_W-1:0]  r_hold_data [NUM_REQ];

    logic [PTR_W-1:0]   r_rr_ptr;

    // Registered broadcast ports
    logic [NUM_PORTS-1:0] r_cdb_valid;
    logic [TAG_W-1:0]     r_cdb_tag  [NUM_PORTS];
    logic [ROB_W-1:0]     r_cdb_rob  [NUM_PORTS];
    logic [DATA_W-1:0]    r_cdb_data [NUM_PORTS];
    logic [SRC_W-1:0]     r_cdb_src  [NUM_PORTS];

    logic [NUM_REQ-1:0] w_cand;
    logic [NUM_REQ-1:0] w_gnt0;
    logic [NUM_REQ-1:0] w_gnt1;
    logic               w_found0;
    logic               w_found1;
    logic [NUM_REQ-1:0] w_grant;
    logic [NUM_REQ-1:0] w_load;

    logic [NUM_REQ-1:0] w_pick       [MAX_PICK];
    logic               w_pick_found [MAX_PICK];
    logic [PTR_W-1:0]   w_pick_idx   [MAX_PICK];
    logic [SRC_W-1:0]   w_pick_src   [MAX_PICK];
    logic [TAG_W-1:0]   w_pick_tag   [MAX_PICK];
    logic [ROB_W-1:0]   w_pick_rob   [MAX_PICK];
    logic [DATA_W-1:0]  w_pick_data  [MAX_PICK];

    logic [PTR_W-1:0]   w_last_idx;
    logic [PTR_W-1:0]   w_next_ptr;

    // Only held entries compete; a flush cycle makes no grants at all
    assign w_cand = flush ? '0 : r_hold_valid;

    rr_pick2 #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .i_valid  (w_cand),
        .i_ptr    (r_rr_ptr),
        .o_gnt0   (w_gnt0),
        .o_gnt1   (w_gnt1),
        .o_found0 (w_found0),
        .o_found1 (w_found1)
    );

    // Map picker lanes onto ports; lane 1 is dropped when only one port exists
    always_comb begin
        w_pick[0]       = w_gnt0;
        w_pick_found[0] = w_found0;
        w_pick[1]       = (LIVE > 1) ? w_gnt1 : '0;
        w_pick_found[1] = (LIVE > 1) && w_found1;
    end

    assign w_grant   = w_pick[0] | w_pick[1];
    // A hold being drained this cycle can accept its successor at the same edge
    assign req_ready = {NUM_REQ{~flush}} & (~r_hold_valid | w_grant);
    assign w_load    = req_valid & req_ready;

    // Select the winning hold register contents for each lane
    always_comb begin
        for (int p = 0; p < MAX_PICK; p++) begin
            w_pick_idx[p]  = '0;
            w_pick_src[p]  = '0;
            w_pick_tag[p]  = '0;
            w_pick_rob[p]  = '0;
            w_pick_data[p] = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_pick[p][i]) begin
                    w_pick_idx[p]  = PTR_W'(i);
                    w_pick_src[p]  = SRC_W'(i);
                    w_pick_tag[p]  = r_hold_tag[i];
                    w_pick_rob[p]  = r_hold_rob[i];
                    w_pick_data[p] = r_hold_data[i];
                end
            end
        end
    end

    // Pointer advances past the last slot served this cycle
    assign w_last_idx = w_pick_found[1] ? w_pick_idx[1] : w_pick_idx[0];
    assign w_next_ptr = PTR_W'(wrap_inc(int'(w_last_idx), NUM_REQ));

    // Hold registers: load on handshake, clear when granted, wipe on flush
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold_valid <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_hold_tag[i]  <= '0;
                r_hold_rob[i]  <= '0;
                r_hold_data[i] <= '0;
            end
        end else if (flush) begin
            r_hold_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_load[i]) begin
                    r_hold_valid[i] <= 1'b1;
                    r_hold_tag[i]   <= req_tag[i*TAG_W +: TAG_W];
                    r_hold_rob[i]   <= req_rob[i*ROB_W +: ROB_W];
                    r_hold_data[i]  <= req_data[i*DATA_W +: DATA_W];
                end else if (w_grant[i]) begin
                    r_hold_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Round-robin pointer moves only when something was granted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (w_pick_found[0]) begin
            r_rr_ptr <= w_next_ptr;
        end
    end

    // Broadcast registers: valid pulses for one cycle, payload held while idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cdb_valid <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_cdb_tag[p]  <= '0;
                r_cdb_rob[p]  <= '0;
                r_cdb_data[p] <= '0;
                r_cdb_src[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (p < LIVE) begin
                    r_cdb_valid[p] <= w_pick_found[p];
                    if (w_pick_found[p]) begin
                        r_cdb_tag[p]  <= w_pick_tag[p];
                        r_cdb_rob[p]  <= w_pick_rob[p];
                        r_cdb_data[p] <= w_pick_data[p];
                        r_cdb_src[p]  <= w_pick_src[p];
                    end
                end else begin
                    r_cdb_valid[p] <= 1'b0;
                end
            end
        end
    end

    assign cdb_valid = r_cdb_valid;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign cdb_tag[p*TAG_W +: TAG_W]    = r_cdb_tag[p];
        assign cdb_rob[p*ROB_W +: ROB_W]    = r_cdb_rob[p];
        assign cdb_data[p*DATA_W +: DATA_W] = r_cdb_data[p];
        assign cdb_src[p*SRC_W +: SRC_W]    = r_cdb_src[p];
    end

endmodule
